// File: rtl/alarm_timer_pkg.sv
// Shared anti-theft definitions: countdown state encoding and seconds width.
package alarm_timer_pkg;

    localparam int SECONDS_W = 4;

    typedef logic [SECONDS_W-1:0] seconds_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COUNT   = 2'b01,
        EXPIRED = 2'b10
    } timer_state_t;

endpackage

// File: rtl/alarm_timer_one_hz_divider.sv
// Module one_hz_divider: free-running prescaler producing a once-per-second
// enable pulse and a 50% duty status blink; 'clear' restarts the second.
module one_hz_divider #(
    parameter int TC = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic one_hz_enable,
    output logic blink
);

    localparam int CNT_W = (TC > 1) ? $clog2(TC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TC - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(TC / 2);

    logic [CNT_W-1:0] count_q;

    // Clearing on a start makes the first second after a start a full one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear || (count_q == LAST)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign one_hz_enable = (count_q == LAST);
    assign blink         = (count_q < HALF);

endmodule

// File: rtl/alarm_timer.sv
// Seconds countdown timer with one-cycle expiry pulse and status blink.
// Define ALARM_TIMER_FAST_SIM_EN to shrink a "second" to 4 clock cycles.
module alarm_timer
    import alarm_timer_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_timer,
    input  logic [SECONDS_W-1:0] value,
    output logic                 expired,
    output logic                 busy,
    output logic [SECONDS_W-1:0] remaining,
    output logic                 one_hz_enable,
    output logic                 blink
);

`ifdef ALARM_TIMER_FAST_SIM_EN
    localparam bit FAST_SIM = 1'b1;
`else
    localparam bit FAST_SIM = 1'b0;
`endif
    localparam int TC = FAST_SIM ? 4 : CLK_HZ;

    timer_state_t state_q;
    timer_state_t state_n;
    seconds_t     remaining_q;
    seconds_t     remaining_n;

    one_hz_divider #(
        .TC(TC)
    ) u_divider (
        .clock         (clock),
        .reset         (reset),
        .clear         (start_timer),
        .one_hz_enable (one_hz_enable),
        .blink         (blink)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_n;
            remaining_q <= remaining_n;
        end
    end

    // A start overrides whatever the countdown was about to do, including expiry.
    always_comb begin
        state_n     = state_q;
        remaining_n = remaining_q;
        case (state_q)
            IDLE: begin
                state_n = IDLE;
            end
            COUNT: begin
                if (one_hz_enable) begin
                    if (remaining_q == seconds_t'(1)) begin
                        remaining_n = '0;
                        state_n     = EXPIRED;
                    end else begin
                        remaining_n = remaining_q - seconds_t'(1);
                    end
                end
            end
            EXPIRED: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (start_timer) begin
            remaining_n = value;
            state_n     = (value != '0) ? COUNT : EXPIRED;
        end
    end

    assign remaining = remaining_q;
    assign busy      = (state_q == COUNT);
    assign expired   = (state_q == EXPIRED);

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer: directed scenarios plus random starts,
// compared each cycle against an arithmetic model of the countdown timeline.
module tb_alarm_timer;

    localparam int CLK_HZ = 8;
`ifdef ALARM_TIMER_FAST_SIM_EN
    localparam int TC = 4;
`else
    localparam int TC = CLK_HZ;
`endif

    logic       clock;
    logic       reset;
    logic       start_timer;
    logic [3:0] value;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
    logic       one_hz_enable;
    logic       blink;

    alarm_timer #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .value         (value),
        .expired       (expired),
        .busy          (busy),
        .remaining     (remaining),
        .one_hz_enable (one_hz_enable),
        .blink         (blink)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a countdown is fully described by its start cycle and length.
    bit act     = 1'b0;
    int st_cyc  = 0;
    int st_n    = 0;
    int t0      = 0;

    int exp_cnt      = 0;
    int busy_cnt     = 0;
    int last_exp_cyc = -1;
    int blink_hi     = 0;
    int tick_q[$];

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic checkAll();
        int phase;
        int d;
        bit e_busy;
        bit e_exp;
        int e_rem;
        phase  = (cyc - t0) % TC;
        e_busy = 1'b0;
        e_exp  = 1'b0;
        e_rem  = 0;
        if (act) begin
            d = cyc - st_cyc;
            if (st_n != 0 && d <= st_n * TC) begin
                e_busy = 1'b1;
                e_rem  = st_n - (d - 1) / TC;
            end else if (d == st_n * TC + 1) begin
                e_exp = 1'b1;
            end
        end
        checkOutput("one_hz_enable", {3'b0, one_hz_enable}, {3'b0, phase == TC - 1});
        checkOutput("blink", {3'b0, blink}, {3'b0, phase < TC / 2});
        checkOutput("busy", {3'b0, busy}, {3'b0, e_busy});
        checkOutput("expired", {3'b0, expired}, {3'b0, e_exp});
        checkOutput("remaining", remaining, 4'(e_rem));
        if (expired === 1'b1) begin
            exp_cnt++;
            last_exp_cyc = cyc;
        end
        if (busy === 1'b1) busy_cnt++;
        if (blink === 1'b1) blink_hi++;
        if (one_hz_enable === 1'b1) tick_q.push_back(cyc);
    endtask

    // Called at a falling edge: check this cycle, drive inputs, advance one cycle.
    task automatic applyStimulus(input bit s, input logic [3:0] v);
        checkAll();
        start_timer = s;
        value       = v;
        @(posedge clock);
        if (s) begin
            act    = 1'b1;
            st_cyc = cyc;
            st_n   = int'(v);
            t0     = cyc + 1;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic clearStats();
        exp_cnt      = 0;
        busy_cnt     = 0;
        last_exp_cyc = -1;
        blink_hi     = 0;
        tick_q.delete();
    endtask

    task automatic applyReset(input int hold);
        reset       = 1'b1;
        start_timer = 1'b0;
        #1;
        checkOutput("rst_busy", {3'b0, busy}, 4'd0);
        checkOutput("rst_expired", {3'b0, expired}, 4'd0);
        checkOutput("rst_remaining", remaining, 4'd0);
        checkOutput("rst_one_hz", {3'b0, one_hz_enable}, 4'd0);
        checkOutput("rst_blink", {3'b0, blink}, 4'd1);
        act = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        reset = 1'b0;
        t0    = cyc;
    endtask

    initial begin
        int s;
        reset       = 1'b0;
        start_timer = 1'b0;
        value       = 4'd0;
        #2;
        applyReset(2);
        idleCycles(TC + 3);

        // Basic 3-second countdown.
        clearStats();
        s = cyc;
        applyStimulus(1'b1, 4'd3);
        idleCycles(3 * TC + 6);
        checkOutput("n3_expired_count", 4'(exp_cnt), 4'd1);
        checkOutput("n3_expiry_delay", 4'(last_exp_cyc - s), 4'(3 * TC + 1));
        n_checks++;
        assert (busy_cnt === 3 * TC) else begin
            n_fail++;
            $error("[TB] FAIL n3_busy_cycles: observed %0d expected %0d", busy_cnt, 3 * TC);
        end

        // Zero-length start expires on the next cycle without ever being busy.
        clearStats();
        s = cyc;
        applyStimulus(1'b1, 4'd0);
        idleCycles(TC + 2);
        checkOutput("n0_expired_count", 4'(exp_cnt), 4'd1);
        checkOutput("n0_expiry_delay", 4'(last_exp_cyc - s), 4'd1);
        checkOutput("n0_busy_cycles", 4'(busy_cnt), 4'd0);

        // value changing mid-count must not affect the running countdown.
        clearStats();
        s = cyc;
        applyStimulus(1'b1, 4'd3);
        idleCycles(5);
        for (int i = 0; i < 3 * TC + 3; i++) applyStimulus(1'b0, 4'd9);
        checkOutput("midchg_expiry_delay", 4'(last_exp_cyc - s), 4'(3 * TC + 1));

        // Restart exactly on the final tick suppresses that expiry.
        clearStats();
        applyStimulus(1'b1, 4'd3);
        idleCycles(3 * TC - 1);
        s = cyc;
        applyStimulus(1'b1, 4'd2);
        idleCycles(2 * TC + 4);
        checkOutput("restart_expired_count", 4'(exp_cnt), 4'd1);
        checkOutput("restart_expiry_delay", 4'(last_exp_cyc - s), 4'(2 * TC + 1));

        // Reset while remaining=2 abandons the countdown.
        clearStats();
        applyStimulus(1'b1, 4'd3);
        idleCycles(TC + 2);
        checkOutput("pre_reset_remaining", remaining, 4'd2);
        applyReset(3);
        clearStats();
        idleCycles(4 * TC);
        checkOutput("post_reset_expired_count", 4'(exp_cnt), 4'd0);

        // Divider period and blink duty measured over two idle seconds.
        clearStats();
        idleCycles(2 * TC);
        checkOutput("tick_count", 4'(tick_q.size()), 4'd2);
        if (tick_q.size() == 2)
            checkOutput("tick_period", 4'(tick_q[1] - tick_q[0]), 4'(TC));
        checkOutput("blink_high_cycles", 4'(blink_hi), 4'(TC));

        // Random starts with random values, value jittering every cycle.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)));
        end
        idleCycles(16 * TC + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
